// File: rtl/sweep_pair_parser_pkg.sv
// Shared types and helpers for the lighthouse sweep pairing stage.
// Holds the FSM state encoding, the channel verdict type and the pair packing order.
package sweep_pair_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLASSIFY = 3'd1,
        CHECK    = 3'd2,
        DROP     = 3'd3,
        STORE    = 3'd4,
        EMIT     = 3'd5,
        HOLD     = 3'd6,
        RELEASE  = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CHK_PASS = 2'd0,
        CHK_KEEP = 2'd1,
        CHK_DROP = 2'd2
    } chk_e;

    // A single channel still needs a one-bit index register.
    function automatic int idx_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    // Channel 0 occupies the most significant pair; each pair is {stored, current}.
    function automatic int pair_lsb(input int k, input int channels, input int iter_w);
        return (channels - 1 - k) * 2 * iter_w;
    endfunction

endpackage

// File: rtl/sweep_pair_parser_if.sv
// Handshake and data bus between pulse identifier, sweep pair parser and sensor consumer.
// The parser connects through the slave modport; the producer/consumer side uses master.
interface sweep_pair_parser_if #(
    parameter int CHANNELS = 8,
    parameter int ITER_W   = 17,
    parameter int POLY_W   = 17
);

    logic                         pulse_identifier_ready;
    logic [CHANNELS*ITER_W-1:0]   iterations;
    logic [POLY_W-1:0]            polynomial;
    logic                         sensor_ack;
    logic [2*CHANNELS*ITER_W-1:0] sensor_iterations;
    logic [POLY_W-1:0]            sensor_polynomial;
    logic                         sensor_data_avl;
    logic                         reset_pulse_identifier;

    modport master (
        output pulse_identifier_ready,
        output iterations,
        output polynomial,
        output sensor_ack,
        input  sensor_iterations,
        input  sensor_polynomial,
        input  sensor_data_avl,
        input  reset_pulse_identifier
    );

    modport slave (
        input  pulse_identifier_ready,
        input  iterations,
        input  polynomial,
        input  sensor_ack,
        output sensor_iterations,
        output sensor_polynomial,
        output sensor_data_avl,
        output reset_pulse_identifier
    );

endinterface

// File: rtl/sweep_pair_parser_channel_check.sv
// Combinational pass/keep/drop verdict for one (stored, current) iteration pair.
// Arithmetic is one bit wider than the counts so the minimum-increase test never wraps.
module sweep_channel_check
    import sweep_pair_pkg::*;
#(
    parameter int ITER_W    = 17,
    parameter int MIN_DIFF  = 7500,
    parameter int HALF_ITER = 60000
) (
    input  logic [ITER_W-1:0] s_i,
    input  logic [ITER_W-1:0] c_i,
    output chk_e              decision_o
);

    logic [ITER_W:0] s_ext;
    logic [ITER_W:0] c_ext;
    logic [ITER_W:0] limit;
    logic            both_zero;

    assign s_ext     = {1'b0, s_i};
    assign c_ext     = {1'b0, c_i};
    assign limit     = s_ext + (ITER_W+1)'(MIN_DIFF);
    assign both_zero = (s_i == '0) && (c_i == '0);

    // A large current count on a failed channel means the stored set is no longer trustworthy.
    always_comb begin
        decision_o = CHK_KEEP;
        if (both_zero || (limit < c_ext)) begin
            decision_o = CHK_PASS;
        end else if (c_ext > (ITER_W+1)'(HALF_ITER)) begin
            decision_o = CHK_DROP;
        end
    end

endmodule

// File: rtl/sweep_pair_parser.sv
// Pairs a stored lighthouse sweep set with the next set of matching polynomial and emits {stored, current}.
// Optional stored-set expiry is enabled with the SWEEP_PAIR_STALE_TIMEOUT_EN macro.
module sweep_pair_parser
    import sweep_pair_pkg::*;
#(
    parameter int CHANNELS  = 8,
    parameter int ITER_W    = 17,
    parameter int POLY_W    = 17,
    parameter int MIN_DIFF  = 7500,
    parameter int HALF_ITER = 60000
`ifdef SWEEP_PAIR_STALE_TIMEOUT_EN
    ,
    parameter int STALE_CYCLES = 1440000
`endif
) (
    input  logic                clk_72MHz,
    input  logic                reset_n,
    sweep_pair_parser_if.slave  bus
);

    localparam int IDX_W  = idx_width(CHANNELS);
    localparam int PAIR_W = 2 * CHANNELS * ITER_W;

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic stored_valid_q, stored_valid_d;
    logic ack_q;
    logic avl_q, avl_d;
    logic rpi_q, rpi_d;
    logic store_en;
    logic emit_en;
    logic expired;

    logic [CHANNELS-1:0][ITER_W-1:0] cur;
    logic [CHANNELS-1:0][ITER_W-1:0] stored_q;
    logic [POLY_W-1:0]               poly_q;
    logic [PAIR_W-1:0]               pairs;
    logic [PAIR_W-1:0]               sens_iter_q;
    logic [POLY_W-1:0]               sens_poly_q;
    chk_e                            verdict;

    assign cur = bus.iterations;

    sweep_channel_check #(
        .ITER_W    (ITER_W),
        .MIN_DIFF  (MIN_DIFF),
        .HALF_ITER (HALF_ITER)
    ) u_check (
        .s_i        (stored_q[idx_q]),
        .c_i        (cur[idx_q]),
        .decision_o (verdict)
    );

    always_comb begin
        pairs = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pairs[pair_lsb(k, CHANNELS, ITER_W) +: 2*ITER_W] = {stored_q[k], cur[k]};
        end
    end

`ifdef SWEEP_PAIR_STALE_TIMEOUT_EN
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    logic [STALE_W-1:0] stale_q, stale_d;

    // Expiry is seen combinationally so a coinciding CLASSIFY already treats the set as gone.
    assign expired = stored_valid_q && (stale_q == STALE_W'(STALE_CYCLES));

    always_comb begin
        stale_d = stale_q;
        if (state_q == STORE) begin
            stale_d = '0;
        end else if (stored_valid_q && !expired) begin
            stale_d = stale_q + 1'b1;
        end
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            stale_q <= '0;
        end else begin
            stale_q <= stale_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        stored_valid_d = stored_valid_q && !expired;
        avl_d          = avl_q;
        rpi_d          = rpi_q;
        store_en       = 1'b0;
        emit_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.pulse_identifier_ready) begin
                    state_d = CLASSIFY;
                end
            end

            CLASSIFY: begin
                if (!stored_valid_q || expired || (bus.polynomial != poly_q)) begin
                    state_d = STORE;
                end else begin
                    state_d = CHECK;
                    idx_d   = '0;
                end
            end

            CHECK: begin
                if (verdict == CHK_PASS) begin
                    if (idx_q == IDX_W'(CHANNELS - 1)) begin
                        state_d = EMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (verdict == CHK_DROP) begin
                    state_d = DROP;
                end else begin
                    state_d = RELEASE;
                end
            end

            DROP: begin
                stored_valid_d = 1'b0;
                state_d        = RELEASE;
            end

            STORE: begin
                store_en       = 1'b1;
                stored_valid_d = 1'b1;
                state_d        = RELEASE;
            end

            EMIT: begin
                emit_en        = 1'b1;
                avl_d          = 1'b1;
                stored_valid_d = 1'b0;
                state_d        = HOLD;
            end

            HOLD: begin
                if (ack_q) begin
                    avl_d   = 1'b0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (bus.pulse_identifier_ready) begin
                    rpi_d = 1'b1;
                end else begin
                    rpi_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            stored_valid_q <= 1'b0;
            ack_q          <= 1'b0;
            avl_q          <= 1'b0;
            rpi_q          <= 1'b0;
            stored_q       <= '0;
            poly_q         <= '0;
            sens_iter_q    <= '0;
            sens_poly_q    <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            stored_valid_q <= stored_valid_d;
            ack_q          <= bus.sensor_ack;
            avl_q          <= avl_d;
            rpi_q          <= rpi_d;
            if (store_en) begin
                stored_q <= cur;
                poly_q   <= bus.polynomial;
            end
            // Emitted data is held until the next EMIT, independent of the avl handshake.
            if (emit_en) begin
                sens_iter_q <= pairs;
                sens_poly_q <= poly_q;
            end
        end
    end

    assign bus.sensor_iterations      = sens_iter_q;
    assign bus.sensor_polynomial      = sens_poly_q;
    assign bus.sensor_data_avl        = avl_q;
    assign bus.reset_pulse_identifier = rpi_q;

endmodule
